branch_predictor_gshare_ras: RTL and testbench
==============================================

Name: branch_predictor_gshare_ras

Overview:
Next-generation fetch-stage branch predictor: parametrised gshare direction predictor, direct-mapped BTB with branch-type field, and a return address stack (RAS).
- Prediction is combinational from fetch_pc in the same cycle.
- Training comes from the EX stage.
- The GHR is updated speculatively at fetch and repaired from a per-branch history snapshot on mispredict.

Parameters:
BTB_ENTRIES, 256, BTB entries (power of 2); BTB_IDX_W = clog2(BTB_ENTRIES)
PHT_ENTRIES, 1024, 2-bit counters (power of 2); PHT_IDX_W = clog2(PHT_ENTRIES)
GHR_WIDTH, PHT_IDX_W, global history bits (1..PHT_IDX_W)
RAS_DEPTH, 8, return stack entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
fetch_pc  in  32  fetch address (word aligned)
fetch_valid  in  1  fetch_pc is a real fetch; gates speculative GHR update
pred_taken  out  1  predicted redirect
pred_target  out  32  predicted next PC
pred_ghr  out  GHR_WIDTH  GHR value used for this prediction; carried down the pipe
ex_valid  in  1  resolved control-flow instruction in EX
ex_type  in  2  00 cond, 01 jump, 10 call, 11 return
ex_pc  in  32  PC of resolved instruction
ex_taken  in  1  actual direction (1 for non-cond)
ex_target  in  32  actual target
ex_ghr  in  GHR_WIDTH  pred_ghr snapshot for this instruction
ex_mispredict  in  1  direction or target mispredicted; qualified by ex_valid

Behaviour:
- Indexing: PHT index = fetch_pc[PHT_IDX_W+1:2] ^ zero-extended ghr at fetch. PHT index = ex_pc[PHT_IDX_W+1:2] ^ ex_ghr at EX.
- BTB index = pc[BTB_IDX_W+1:2]; tag = pc[31:BTB_IDX_W+2]. Each entry holds valid, tag, target[31:0], type[1:0].
- Prediction on BTB hit:
  - cond: pred_taken = counter[1], target = BTB target.
  - jump/call: pred_taken = 1, target = BTB target.
  - return: pred_taken = (ras_count != 0), target = RAS top.
- On BTB miss: pred_taken = 0. Whenever pred_taken = 0, pred_target = fetch_pc + 4 (mod 2^32).
- pred_ghr = current ghr.
- Speculative GHR: when fetch_valid and BTB hit with type cond, ghr <= {ghr[GHR_WIDTH-2:0], counter[1]} next cycle. Otherwise ghr holds.
- Recovery: when ex_valid & ex_mispredict:
  - cond: ghr <= {ex_ghr[GHR_WIDTH-2:0], ex_taken}.
  - other types: ghr <= ex_ghr.
  - Recovery has priority; a same-cycle fetch shift is discarded.
- PHT training: ex_valid & type cond updates PHT[ex index] as a 2-bit saturating counter, +1 if taken, -1 if not. Saturates at 11 and 00.
- BTB allocate/update: ex_valid and (ex_taken or type != cond). On a miss, or a hit with differing target or type, write valid = 1, tag, ex_target, ex_type. A not-taken cond branch on a miss allocates nothing.
- RAS: updated at EX only (non-speculative).
  - Call pushes ex_pc + 4 at ptr, ptr++ (wraps mod RAS_DEPTH), count = min(count + 1, RAS_DEPTH). A push when full overwrites the oldest entry.
  - Return with count > 0: ptr--, count--. Return with count == 0: ignored.
  - Top = stack[ptr - 1].
- Write/read same cycle: all PHT/BTB/RAS/GHR writes take effect at the next edge. Same-cycle fetch lookups see the pre-write state; no bypass.
- Latency: prediction 0 cycles (combinational). Training visible to fetch 1 cycle after the EX cycle.
- Reset (rst = 0 at posedge):
  - ghr = 0, ras ptr = 0, ras count = 0.
  - All BTB valid = 0; all PHT = 01 (weakly not-taken).
  - While rst = 0: pred_taken = 0, pred_target = fetch_pc + 4, pred_ghr = 0. EX inputs are ignored.
  - Reset mid-operation discards all history and state.

Test Plan:
- Reset, fetch_pc = 0x100 -> pred_taken = 0, pred_target = 0x104, pred_ghr = 0.
- EX cond 0x200 taken -> 0x300, ex_ghr = 0 -> BTB alloc, PHT[0x080] 01 -> 10. Next cycle fetch 0x200 (fetch_valid = 1) -> pred_taken = 1, pred_target = 0x300, pred_ghr = 0; following cycle pred_ghr = 1.
- Four further taken updates at same index -> counter 11 holds. One not-taken -> 10, still predicts taken. Two more not-taken -> 00, pred_target = 0x204.
- Return at 0x900 previously allocated; EX call 0x400 -> 0x800 pushes 0x404 -> fetch 0x900 predicts taken, target 0x404.
- RAS: with a return at 0x900 already allocated, 9 calls (RAS_DEPTH = 8) then 8 returns -> count reaches 0; fetch 0x900 predicts not-taken, target 0x904.
- Same cycle: fetch hit on cond and EX mispredict cond, ex_ghr = 0x005, ex_taken = 0 -> ghr = 0x00A next cycle, fetch shift discarded.
- Assert rst = 0 mid-run after training -> BTB/PHT/RAS cleared; fetch 0x200 -> pred_taken = 0.

Source files
------------

// File: rtl/branch_predictor_gshare_ras.sv
// Fetch-stage branch predictor: gshare direction predictor, direct-mapped BTB
// with a branch-type field, and a non-speculative return address stack.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   fetch_pc/valid      fetch address, and whether it is a real fetch
//   pred_taken/target   combinational prediction for fetch_pc
//   pred_ghr            history used for this prediction (carried to EX)
//   ex_*                resolved control-flow instruction from EX (training,
//                       BTB allocation, RAS update, GHR recovery)
module branch_predictor_gshare_ras #(
    parameter int BTB_ENTRIES = 256,
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_WIDTH   = $clog2(PHT_ENTRIES),
    parameter int RAS_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          fetch_pc,
    input  logic                 fetch_valid,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 ex_valid,
    input  logic [1:0]           ex_type,
    input  logic [31:0]          ex_pc,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    input  logic [GHR_WIDTH-1:0] ex_ghr,
    input  logic                 ex_mispredict
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam int TAG_W     = 32 - BTB_IDX_W - 2;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    localparam logic [1:0] TYPE_COND = 2'b00;
    localparam logic [1:0] TYPE_JUMP = 2'b01;
    localparam logic [1:0] TYPE_CALL = 2'b10;
    localparam logic [1:0] TYPE_RET  = 2'b11;

    // Storage
    logic                 btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [31:0]          btb_target_q [BTB_ENTRIES];
    logic [1:0]           btb_type_q   [BTB_ENTRIES];
    logic [1:0]           pht_q        [PHT_ENTRIES];
    logic [31:0]          ras_q        [RAS_DEPTH];

    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;

    // Word-offset bits never take part in any lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

    // ---------------- Fetch-side lookup ----------------
    logic [BTB_IDX_W-1:0] f_btb_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 f_hit;
    logic [1:0]           f_type;
    logic [PHT_IDX_W-1:0] f_pht_idx;
    logic                 f_ctr_taken;
    logic [31:0]          ras_top;
    logic                 taken_raw;
    logic [31:0]          target_raw;

    assign f_btb_idx   = fetch_pc[BTB_IDX_W+1:2];
    assign f_tag       = fetch_pc[31:BTB_IDX_W+2];
    assign f_hit       = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
    assign f_type      = btb_type_q[f_btb_idx];
    assign f_pht_idx   = fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign f_ctr_taken = pht_q[f_pht_idx][1];
    assign ras_top     = ras_q[ras_ptr_q - RAS_PTR_W'(1)];

    always_comb begin
        taken_raw  = 1'b0;
        target_raw = btb_target_q[f_btb_idx];
        if (rst && f_hit) begin
            case (f_type)
                TYPE_COND: taken_raw = f_ctr_taken;
                TYPE_JUMP,
                TYPE_CALL: taken_raw = 1'b1;
                default: begin
                    taken_raw  = (ras_cnt_q != '0);
                    target_raw = ras_top;
                end
            endcase
        end
    end

    assign pred_taken  = taken_raw;
    assign pred_target = taken_raw ? target_raw : (fetch_pc + 32'd4);
    assign pred_ghr    = rst ? ghr_q : '0;

    // ---------------- Global history ----------------
    // Shifts are written as truncating casts so GHR_WIDTH = 1 stays legal.
    always_comb begin
        ghr_d = ghr_q;
        if (ex_valid && ex_mispredict) begin
            ghr_d = (ex_type == TYPE_COND) ? GHR_WIDTH'({ex_ghr, ex_taken}) : ex_ghr;
        end else if (fetch_valid && f_hit && (f_type == TYPE_COND)) begin
            ghr_d = GHR_WIDTH'({ghr_q, f_ctr_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) ghr_q <= '0;
        else      ghr_q <= ghr_d;
    end

    // ---------------- PHT training ----------------
    logic [PHT_IDX_W-1:0] e_pht_idx;
    logic [1:0]           e_ctr;

    assign e_pht_idx = ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ex_ghr);
    assign e_ctr     = pht_q[e_pht_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[PHT_IDX_W'(i)] <= 2'b01;
            end
        end else if (ex_valid && (ex_type == TYPE_COND)) begin
            if (ex_taken && (e_ctr != 2'b11)) begin
                pht_q[e_pht_idx] <= e_ctr + 2'd1;
            end else if (!ex_taken && (e_ctr != 2'b00)) begin
                pht_q[e_pht_idx] <= e_ctr - 2'd1;
            end
        end
    end

    // ---------------- BTB allocate / update ----------------
    logic [BTB_IDX_W-1:0] e_btb_idx;
    logic [TAG_W-1:0]     e_tag;
    logic                 e_hit;
    logic                 e_same;
    logic                 btb_wr;

    assign e_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign e_tag     = ex_pc[31:BTB_IDX_W+2];
    assign e_hit     = btb_valid_q[e_btb_idx] && (btb_tag_q[e_btb_idx] == e_tag);
    assign e_same    = e_hit && (btb_target_q[e_btb_idx] == ex_target)
                             && (btb_type_q[e_btb_idx] == ex_type);
    assign btb_wr    = rst && ex_valid && (ex_taken || (ex_type != TYPE_COND)) && !e_same;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[BTB_IDX_W'(i)] <= 1'b0;
            end
        end else if (btb_wr) begin
            btb_valid_q[e_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag_q[e_btb_idx]    <= e_tag;
            btb_target_q[e_btb_idx] <= ex_target;
            btb_type_q[e_btb_idx]   <= ex_type;
        end
    end

    // ---------------- Return address stack ----------------
    // Circular buffer: a push when full overwrites the oldest slot, which is
    // exactly the slot at ptr, so only the count needs saturating.
    logic ras_push, ras_pop;

    assign ras_push = rst && ex_valid && (ex_type == TYPE_CALL);
    assign ras_pop  = ex_valid && (ex_type == TYPE_RET) && (ras_cnt_q != '0);

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push) begin
            ras_ptr_d = ras_ptr_q + RAS_PTR_W'(1);
            if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - RAS_PTR_W'(1);
            ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) ras_q[ras_ptr_q] <= ex_pc + 32'd4;
    end

endmodule

// File: tb/tb_branch_predictor_gshare_ras.sv
// Directed self-checking bench for branch_predictor_gshare_ras (default
// parameters: 256-entry BTB, 1024-entry PHT, 10-bit GHR, 8-deep RAS).
module tb_branch_predictor_gshare_ras;

    localparam int GW = 10;
    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_JUMP = 2'b01;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fetch_pc;
    logic          fetch_valid;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [GW-1:0] pred_ghr;
    logic          ex_valid;
    logic [1:0]    ex_type;
    logic [31:0]   ex_pc;
    logic          ex_taken;
    logic [31:0]   ex_target;
    logic [GW-1:0] ex_ghr;
    logic          ex_mispredict;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare_ras #(
        .BTB_ENTRIES(256),
        .PHT_ENTRIES(1024),
        .GHR_WIDTH  (GW),
        .RAS_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_ghr     (pred_ghr),
        .ex_valid     (ex_valid),
        .ex_type      (ex_type),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .ex_ghr       (ex_ghr),
        .ex_mispredict(ex_mispredict)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_op(input logic [1:0] t, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [GW-1:0] g, input logic mp);
        ex_valid      = 1'b1;
        ex_type       = t;
        ex_pc         = pc;
        ex_taken      = tk;
        ex_target     = tgt;
        ex_ghr        = g;
        ex_mispredict = mp;
        tick();
        ex_valid      = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
        fetch_pc = pc;
        #1;
        check_eq({tag, "_taken"}, 32'(pred_taken), 32'(tk));
        check_eq({tag, "_target"}, pred_target, tgt);
    endtask

    task automatic check_ghr(input string tag, input logic [GW-1:0] exp);
        #1;
        check_eq(tag, 32'(pred_ghr), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; fetch_pc = 32'h100; fetch_valid = 1'b0;
        ex_valid = 1'b0; ex_type = T_COND; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_ghr = '0; ex_mispredict = 1'b0;

        // Reset state
        tick(); tick();
        probe("rst_hold", 32'h100, 1'b0, 32'h104);
        check_ghr("rst_hold_ghr", '0);
        rst = 1'b1;
        probe("post_rst", 32'h100, 1'b0, 32'h104);
        check_ghr("post_rst_ghr", '0);

        // First taken cond trains PHT[0x080] 01->10 and allocates the BTB
        ex_op(T_COND, 32'h200, 1'b1, 32'h300, '0, 1'b0);
        fetch_valid = 1'b1;
        probe("cond_alloc", 32'h200, 1'b1, 32'h300);
        check_ghr("cond_alloc_ghr", '0);
        tick();
        fetch_valid = 1'b0;
        check_ghr("spec_shift_ghr", 10'h001);

        // Restore ghr to 0 via a not-taken cond mispredict (no BTB alloc)
        ex_op(T_COND, 32'hA00, 1'b0, 32'h0, '0, 1'b1);
        check_ghr("restore_ghr", '0);

        // Saturation: 10 -> 11 held, then down to 00 held
        repeat (4) ex_op(T_COND, 32'h200, 1'b1, 32'h300, '0, 1'b0);
        probe("sat_hi", 32'h200, 1'b1, 32'h300);
        ex_op(T_COND, 32'h200, 1'b0, 32'h300, '0, 1'b0);
        probe("nt_once", 32'h200, 1'b1, 32'h300);
        ex_op(T_COND, 32'h200, 1'b0, 32'h300, '0, 1'b0);
        probe("nt_twice", 32'h200, 1'b0, 32'h204);
        ex_op(T_COND, 32'h200, 1'b0, 32'h300, '0, 1'b0);
        ex_op(T_COND, 32'h200, 1'b0, 32'h300, '0, 1'b0);
        probe("sat_lo", 32'h200, 1'b0, 32'h204);

        // Return allocated with an empty RAS, then a call supplies the target
        ex_op(T_RET, 32'h900, 1'b1, 32'h1234, '0, 1'b0);
        probe("ret_empty", 32'h900, 1'b0, 32'h904);
        ex_op(T_CALL, 32'h400, 1'b1, 32'h800, '0, 1'b0);
        probe("ret_top", 32'h900, 1'b1, 32'h404);
        probe("call_hit", 32'h400, 1'b1, 32'h800);

        // Overfill: 9 calls wrap the 8-deep stack, then drain with 8 returns
        for (int i = 0; i < 9; i++) begin
            ex_op(T_CALL, 32'h2000 + 32'(16 * i), 1'b1, 32'h800, '0, 1'b0);
        end
        probe("ras_full", 32'h900, 1'b1, 32'h2084);
        for (int k = 1; k <= 8; k++) begin
            ex_op(T_RET, 32'h900, 1'b1, 32'h1234, '0, 1'b0);
            if (k < 8) probe($sformatf("ras_pop%0d", k), 32'h900, 1'b1, 32'h2084 - 32'(16 * k));
            else       probe("ras_drained", 32'h900, 1'b0, 32'h904);
        end
        ex_op(T_RET, 32'h900, 1'b1, 32'h1234, '0, 1'b0);
        probe("ras_underflow", 32'h900, 1'b0, 32'h904);

        // Same cycle: recovery beats the speculative fetch shift
        fetch_pc = 32'h200; fetch_valid = 1'b1;
        ex_valid = 1'b1; ex_type = T_COND; ex_pc = 32'hA00; ex_taken = 1'b0;
        ex_target = '0; ex_ghr = 10'h005; ex_mispredict = 1'b1;
        tick();
        ex_valid = 1'b0; ex_mispredict = 1'b0; fetch_valid = 1'b0;
        check_ghr("recover_cond_ghr", 10'h00A);

        // Non-cond recovery restores the snapshot unshifted
        ex_op(T_JUMP, 32'h3010, 1'b1, 32'h5000, 10'h155, 1'b1);
        check_ghr("recover_jump_ghr", 10'h155);
        probe("jump_hit", 32'h3010, 1'b1, 32'h5000);

        // Build state to be discarded by a mid-run reset
        ex_op(T_CALL, 32'h400, 1'b1, 32'h800, 10'h155, 1'b0);
        probe("pre_rst_ret", 32'h900, 1'b1, 32'h404);
        probe("pre_rst_call", 32'h400, 1'b1, 32'h800);

        rst = 1'b0;
        ex_valid = 1'b1; ex_type = T_CALL; ex_pc = 32'h440; ex_taken = 1'b1;
        ex_target = 32'h999; ex_ghr = '0; ex_mispredict = 1'b0;
        probe("in_rst", 32'h400, 1'b0, 32'h404);
        check_ghr("in_rst_ghr", '0);
        tick();
        ex_valid = 1'b0; rst = 1'b1;
        probe("rst2_call", 32'h400, 1'b0, 32'h404);
        probe("rst2_ex_ignored", 32'h440, 1'b0, 32'h444);
        probe("rst2_cond", 32'h200, 1'b0, 32'h204);
        check_ghr("rst2_ghr", '0);
        ex_op(T_RET, 32'h900, 1'b1, 32'h1234, '0, 1'b0);
        probe("rst2_ras_empty", 32'h900, 1'b0, 32'h904);
        ex_op(T_COND, 32'h200, 1'b1, 32'h300, '0, 1'b0);
        probe("rst2_pht_weak", 32'h200, 1'b1, 32'h300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
